cnt_seg_display: RTL and testbench

//   Display stage fed by the 8-bit up/down binary counter. Takes the counter

---
 rtl/cnt_seg_display.sv | 166 ++++++++++++++++
 tb/tb_cnt_seg_display.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_seg_display
//  Description : Converts an 8-bit binary value into 3-digit BCD with a
//                sequential shift-add-3 (double-dabble) engine, one shift per
//                clock. Drives a multiplexed common-anode 3-digit 7-segment
//                display with leading-zero blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_seg_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_value,
  output logic [11:0] o_bcd,
  output logic        o_bcd_valid,
  output logic        o_busy,
  output logic [2:0]  o_an,
  output logic [6:0]  o_seg
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int              c_cnt_w     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [6:0]      c_seg_blank = 7'b1111111;

  // --------------------------------------------------------------------------
  // Converter state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_bin;        // binary bits still to be shifted into the BCD field
  logic [11:0] r_work;       // BCD field being built {hundreds,tens,units}
  logic [7:0]  r_last;       // value most recently loaded into the engine
  logic        r_force;      // forces one conversion after reset
  logic [2:0]  r_bit_cnt;    // number of shifts already performed
  logic [11:0] w_adj;        // BCD field after the add-3 correction

  // --------------------------------------------------------------------------
  // Scanner state
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0] r_scan_cnt;
  logic [1:0]         r_idx;
  logic [3:0]         w_nib;
  logic               w_blank;

  // Active-low 7-segment glyph for one BCD digit; non-decimal codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = c_seg_blank;
    endcase
    return s;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more so the next shift carries correctly.
  always_comb begin
    w_adj[3:0]  = (r_work[3:0]  >= 4'd5) ? (r_work[3:0]  + 4'd3) : r_work[3:0];
    w_adj[7:4]  = (r_work[7:4]  >= 4'd5) ? (r_work[7:4]  + 4'd3) : r_work[7:4];
    w_adj[11:8] = (r_work[11:8] >= 4'd5) ? (r_work[11:8] + 4'd3) : r_work[11:8];
  end

  // Converter FSM: load on change, eight correct-and-shift steps, then publish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_bin       <= 8'd0;
      r_work      <= 12'd0;
      r_last      <= 8'd0;
      r_force     <= 1'b1;
      r_bit_cnt   <= 3'd0;
      o_bcd       <= 12'h000;
      o_bcd_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_bcd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_force || (i_value != r_last)) begin
            r_bin     <= i_value;
            r_work    <= 12'd0;
            r_last    <= i_value;
            r_force   <= 1'b0;
            r_bit_cnt <= 3'd0;
            o_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // {bcd,bin} shifted left by one after the correction
          r_work    <= {w_adj[10:0], r_bin[7]};
          r_bin     <= {r_bin[6:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          o_bcd       <= r_work;
          o_bcd_valid <= 1'b1;
          o_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Digit scanner: hold each digit for SCAN_DIV clocks, then step units->tens->hundreds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == c_scan_last) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Select the lit digit, apply leading-zero blanking and decode to segments.
  always_comb begin
    w_nib   = o_bcd[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd1: begin
        w_nib   = o_bcd[7:4];
        w_blank = (o_bcd[11:8] == 4'd0) && (o_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib   = o_bcd[11:8];
        w_blank = (o_bcd[11:8] == 4'd0);
      end
      default: begin
        w_nib   = o_bcd[3:0];
        w_blank = 1'b0;
      end
    endcase
    o_an  = ~(3'b001 << r_idx);
    o_seg = w_blank ? c_seg_blank : seg_decode(w_nib);
  end

endmodule
`default_nettype wire

// File: tb/tb_cnt_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_seg_display
//  Description : Self-checking bench for cnt_seg_display against a decimal
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnt_seg_display;

  localparam int c_scan_div = 4;
  localparam int c_lat      = 10;  // samples from change-edge k through edge k+9

  logic        clk;
  logic        rst;
  logic [7:0]  i_value;
  logic [11:0] o_bcd;
  logic        o_bcd_valid;
  logic        o_busy;
  logic [2:0]  o_an;
  logic [6:0]  o_seg;

  int n_tests = 0;
  int n_fail  = 0;
  int shown   = 0;           // value the model expects on the display
  int scan_edges = 0;        // clock edges since the last reset edge

  cnt_seg_display #(.SCAN_DIV(c_scan_div)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_value     (i_value),
    .o_bcd       (o_bcd),
    .o_bcd_valid (o_bcd_valid),
    .o_busy      (o_busy),
    .o_an        (o_an),
    .o_seg       (o_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) scan_edges <= 0;
    else     scan_edges <= scan_edges + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic [11:0] bcd_of(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int cur_idx();
    return (scan_edges / c_scan_div) % 3;
  endfunction

  function automatic logic [2:0] exp_an(input int idx);
    if (idx == 0) return 3'b110;
    if (idx == 1) return 3'b101;
    return 3'b011;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (idx == 0) return glyph(u);
    if (idx == 1) return (h == 0 && t == 0) ? 7'b1111111 : glyph(t);
    return (h == 0) ? 7'b1111111 : glyph(h);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (o_bcd_valid !== 1'b1 && steps < 40);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat;
    rst = 1'b1;
    i_value = 8'd0;
    step();
    step();
    n_tests++; if (o_an !== 3'b110) begin n_fail++; $display("FAIL reset_an got=%b exp=110", o_an); end
    n_tests++; if (o_seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg got=%b exp=1000000", o_seg); end
    n_tests++; if (o_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=000", o_bcd); end
    n_tests++; if (o_bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_bcd_valid); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    rst = 1'b0;
    wait_valid(lat);
    n_tests++; if (lat != c_lat) begin n_fail++; $display("FAIL reset_reconv_latency got=%0d exp=%0d", lat, c_lat); end
    n_tests++; if (o_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_reconv_bcd got=%h exp=000", o_bcd); end
    shown = 0;
  endtask

  task automatic test_full_scale();
    i_value = 8'd255;
    for (int i = 1; i <= c_lat; i++) begin
      step();
      if (i < c_lat) begin
        n_tests++;
        if (o_busy !== 1'b1 || o_bcd_valid !== 1'b0) begin
          n_fail++; $display("FAIL full_busy step=%0d busy=%b valid=%b exp busy=1 valid=0", i, o_busy, o_bcd_valid);
        end
      end
    end
    n_tests++; if (o_bcd_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got=%b exp=1", o_bcd_valid); end
    n_tests++; if (o_bcd !== 12'h255) begin n_fail++; $display("FAIL full_bcd got=%h exp=255", o_bcd); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end got=%b exp=0", o_busy); end
    shown = 255;
    step();
    n_tests++; if (o_bcd_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_pulse got=%b exp=0", o_bcd_valid); end
  endtask

  task automatic test_scan();
    int lat;
    i_value = 8'd9;
    wait_valid(lat);
    n_tests++; if (o_bcd !== 12'h009 || lat != c_lat) begin n_fail++; $display("FAIL scan_setup bcd=%h lat=%0d exp bcd=009 lat=%0d", o_bcd, lat, c_lat); end
    shown = 9;
    for (int i = 0; i < 3 * c_scan_div; i++) begin
      n_tests++;
      if (o_an !== exp_an(cur_idx()) || o_seg !== exp_seg(shown, cur_idx())) begin
        n_fail++; $display("FAIL scan_digit an=%b seg=%b exp an=%b seg=%b", o_an, o_seg, exp_an(cur_idx()), exp_seg(shown, cur_idx()));
      end
      step();
    end
  endtask

  task automatic test_midflight();
    int lat;
    i_value = 8'd17;
    wait_valid(lat);
    n_tests++; if (o_bcd !== 12'h017) begin n_fail++; $display("FAIL mid_pre bcd=%h exp=017", o_bcd); end
    i_value = 8'd200;
    step(); step(); step();
    i_value = 8'd42;
    wait_valid(lat);
    n_tests++; if (o_bcd !== 12'h200 || lat != c_lat - 3) begin n_fail++; $display("FAIL mid_first bcd=%h lat=%0d exp bcd=200 lat=%0d", o_bcd, lat, c_lat - 3); end
    wait_valid(lat);
    n_tests++; if (o_bcd !== 12'h042 || lat != c_lat) begin n_fail++; $display("FAIL mid_second bcd=%h lat=%0d exp bcd=042 lat=%0d", o_bcd, lat, c_lat); end
    shown = 42;
    for (int i = 0; i < 3 * c_scan_div; i++) begin
      n_tests++;
      if (o_an !== exp_an(cur_idx()) || o_seg !== exp_seg(shown, cur_idx())) begin
        n_fail++; $display("FAIL mid_display an=%b seg=%b exp an=%b seg=%b", o_an, o_seg, exp_an(cur_idx()), exp_seg(shown, cur_idx()));
      end
      step();
    end
  endtask

  task automatic test_reset_midconv();
    int v, lat;
    v = (shown + 1 + int'($urandom_range(0, 253))) % 256;
    i_value = v[7:0];
    step(); step(); step(); step();   // edges k..k+3
    rst = 1'b1;
    step();                            // edge k+4
    shown = 0;
    n_tests++; if (o_bcd !== 12'h000 || o_bcd_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state bcd=%h valid=%b busy=%b exp 000/0/0", o_bcd, o_bcd_valid, o_busy);
    end
    n_tests++; if (o_an !== 3'b110 || o_seg !== 7'b1000000) begin
      n_fail++; $display("FAIL rstmid_display an=%b seg=%b exp an=110 seg=1000000", o_an, o_seg);
    end
    rst = 1'b0;
    wait_valid(lat);
    n_tests++; if (lat != c_lat || o_bcd !== bcd_of(v)) begin
      n_fail++; $display("FAIL rstmid_reconv lat=%0d bcd=%h exp lat=%0d bcd=%h", lat, o_bcd, c_lat, bcd_of(v));
    end
    shown = v;
  endtask

  task automatic sweep_one(input int v);
    int lat;
    i_value = v[7:0];
    wait_valid(lat);
    n_tests++;
    if (lat != c_lat || o_bcd !== bcd_of(v)) begin
      n_fail++; $display("FAIL sweep v=%0d lat=%0d bcd=%h exp lat=%0d bcd=%h", v, lat, o_bcd, c_lat, bcd_of(v));
    end
    shown = v;
    n_tests++;
    if (o_an !== exp_an(cur_idx()) || o_seg !== exp_seg(shown, cur_idx())) begin
      n_fail++; $display("FAIL sweep_display v=%0d an=%b seg=%b exp an=%b seg=%b", v, o_an, o_seg, exp_an(cur_idx()), exp_seg(shown, cur_idx()));
    end
  endtask

  task automatic test_sweep();
    sweep_one(128);
    for (int v = 0; v <= 255; v++) sweep_one(v);
    for (int v = 254; v >= 0; v--) sweep_one(v);
  endtask

  task automatic test_random_retrigger();
    int v;
    v = shown;
    for (int it = 0; it < 15; it++) begin
      int nchg;
      nchg = 1 + int'($urandom_range(0, 3));
      for (int c = 0; c < nchg; c++) begin
        v = int'($urandom_range(0, 255));
        i_value = v[7:0];
        repeat ($urandom_range(1, 12)) step();
      end
      repeat (25) step();
      shown = v;
      n_tests++;
      if (o_bcd !== bcd_of(v) || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL random_settle v=%0d bcd=%h busy=%b exp bcd=%h busy=0", v, o_bcd, o_busy, bcd_of(v));
      end
      n_tests++;
      if (o_an !== exp_an(cur_idx()) || o_seg !== exp_seg(shown, cur_idx())) begin
        n_fail++; $display("FAIL random_display v=%0d an=%b seg=%b exp an=%b seg=%b", v, o_an, o_seg, exp_an(cur_idx()), exp_seg(shown, cur_idx()));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_value = 8'd0;
    test_reset();
    test_full_scale();
    test_scan();
    test_midflight();
    test_reset_midconv();
    test_sweep();
    test_random_retrigger();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
